// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI master arbiter: state encoding, default
// timing constants and small helpers used by the FSM timers.
package spi_arb_pkg;

  // State encoding, kept stable so the state register is easy to decode on a probe.
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_MSETUP  = 4'd1;
  localparam logic [3:0] ST_CSSETUP = 4'd2;
  localparam logic [3:0] ST_START   = 4'd3;
  localparam logic [3:0] ST_WAITB   = 4'd4;
  localparam logic [3:0] ST_XFER    = 4'd5;
  localparam logic [3:0] ST_HOLD    = 4'd6;
  localparam logic [3:0] ST_RESP    = 4'd7;
  localparam logic [3:0] ST_GAP     = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE    = ST_IDLE,
    S_MSETUP  = ST_MSETUP,
    S_CSSETUP = ST_CSSETUP,
    S_START   = ST_START,
    S_WAITB   = ST_WAITB,
    S_XFER    = ST_XFER,
    S_HOLD    = ST_HOLD,
    S_RESP    = ST_RESP,
    S_GAP     = ST_GAP
  } arb_state_e;

  // Default configuration.
  localparam int DEF_N          = 4;
  localparam int DEF_MODE_SETUP = 4;
  localparam int DEF_CS_SETUP   = 2;
  localparam int DEF_CS_HOLD    = 2;
  localparam int DEF_GAP        = 2;
  localparam int DEF_TIMEOUT    = 4096;

  // Largest of four values; sizes the shared phase counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // A timed state has run its course once cnt+1 reaches lim. A limit of 0
  // therefore still spends exactly one cycle in the state.
  function automatic logic tmr_expired(input int cnt, input int lim);
    return (cnt + 1) >= lim;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward
// from ptr_i+1, wrapping modulo N. Returns one-hot grant, index and valid.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan N positions starting just after the last winner; first hit wins.
  always_comb begin
    int k;
    k       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 1; off <= N; off++) begin
      k = (int'(ptr_i) + off) % N;
      if (!valid_o && req_i[k]) begin
        valid_o    = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one spi_master between N requesters. Each grant runs one 8-bit
// transfer: mode setup with all CS high, CS assert, start pulse, wait for the
// engine, CS hold, then a done pulse carrying the received byte.
// Optional build macro SPI_ARB_TIMEOUT_EN adds a WAITB/XFER watchdog
// (parameter TIMEOUT) and an err output that pulses with done on expiry.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int MODE_SETUP = DEF_MODE_SETUP,
  parameter int CS_SETUP   = DEF_CS_SETUP,
  parameter int CS_HOLD    = DEF_CS_HOLD,
  parameter int GAP        = DEF_GAP
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = DEF_TIMEOUT
`endif
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_cpol,
  input  logic [N-1:0]   req_cpha,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [7:0]     rsp_data,
  output logic [N-1:0]   cs_n,
  output logic           m_start,
  output logic [7:0]     m_data_in,
  output logic           m_cpol,
  output logic           m_cpha,
  input  logic           m_busy,
  input  logic [7:0]     m_data_out
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic           err
`endif
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(max4(MODE_SETUP, CS_SETUP, CS_HOLD, GAP)) + 1;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT) + 1;
`endif

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic [N-1:0]  win_oh_q, win_oh_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_cpol_q, m_cpol_d;
  logic          m_cpha_q, m_cpha_d;
  logic [7:0]    rsp_q, rsp_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [N-1:0]  cs_n_q, cs_n_d;
  logic          m_start_q, m_start_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [WW-1:0] wd_q, wd_d;
  logic          to_q, to_d;
  logic          err_q, err_d;
`endif

  logic [N-1:0]  arb_grant;
  logic [IW-1:0] arb_idx;
  logic          arb_valid;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Transaction sequencer: next state, phase counter and latched transfer context.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    win_oh_d = win_oh_q;
    m_data_d = m_data_q;
    m_cpol_d = m_cpol_q;
    m_cpha_d = m_cpha_q;
    rsp_d    = rsp_q;
`ifdef SPI_ARB_TIMEOUT_EN
    wd_d     = wd_q;
    to_d     = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (arb_valid) begin
          // Snapshot the winner's byte and mode; later changes on req_* are ignored.
          win_d    = arb_idx;
          win_oh_d = arb_grant;
          m_data_d = req_data[{arb_idx, 3'b000} +: 8];
          m_cpol_d = req_cpol[arb_idx];
          m_cpha_d = req_cpha[arb_idx];
          state_d  = S_MSETUP;
`ifdef SPI_ARB_TIMEOUT_EN
          to_d     = 1'b0;
`endif
        end
      end
      S_MSETUP: begin
        if (tmr_expired(int'(cnt_q), MODE_SETUP)) begin
          cnt_d   = '0;
          state_d = S_CSSETUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CSSETUP: begin
        if (tmr_expired(int'(cnt_q), CS_SETUP)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAITB;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAITB: begin
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        if (m_busy) begin
          state_d = S_XFER;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmr_expired(int'(wd_q), TIMEOUT)) begin
          cnt_d   = '0;
          rsp_d   = 8'hFF;
          to_d    = 1'b1;
          state_d = S_HOLD;
        end
`endif
      end
      S_XFER: begin
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        if (!m_busy) begin
          cnt_d   = '0;
          rsp_d   = m_data_out;
          state_d = S_HOLD;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmr_expired(int'(wd_q), TIMEOUT)) begin
          cnt_d   = '0;
          rsp_d   = 8'hFF;
          to_d    = 1'b1;
          state_d = S_HOLD;
        end
`endif
      end
      S_HOLD: begin
        if (tmr_expired(int'(cnt_q), CS_HOLD)) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = win_q;
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (tmr_expired(int'(cnt_q), GAP)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a plain flop.
  always_comb begin
    gnt_d     = '0;
    cs_n_d    = '1;
    done_d    = '0;
    m_start_d = (state_d == S_START);
    if (state_d inside {S_MSETUP, S_CSSETUP, S_START, S_WAITB, S_XFER, S_HOLD}) begin
      gnt_d = win_oh_d;
    end
    if (state_d inside {S_CSSETUP, S_START, S_WAITB, S_XFER, S_HOLD}) begin
      cs_n_d = ~win_oh_d;
    end
    if (state_d == S_RESP) begin
      done_d = win_oh_d;
    end
`ifdef SPI_ARB_TIMEOUT_EN
    err_d = (state_d == S_RESP) && to_q;
`endif
  end

  // State and output registers; reset drops CS immediately but leaves the engine alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= IW'(N - 1);
      win_q     <= '0;
      win_oh_q  <= '0;
      m_data_q  <= '0;
      m_cpol_q  <= 1'b0;
      m_cpha_q  <= 1'b0;
      rsp_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      cs_n_q    <= '1;
      m_start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q      <= '0;
      to_q      <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      win_oh_q  <= win_oh_d;
      m_data_q  <= m_data_d;
      m_cpol_q  <= m_cpol_d;
      m_cpha_q  <= m_cpha_d;
      rsp_q     <= rsp_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      m_start_q <= m_start_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q      <= wd_d;
      to_q      <= to_d;
      err_q     <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_data  = rsp_q;
  assign cs_n      = cs_n_q;
  assign m_start   = m_start_q;
  assign m_data_in = m_data_q;
  assign m_cpol    = m_cpol_q;
  assign m_cpha    = m_cpha_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter (N=4, default timing) with a small
// behavioural spi_master. Handles both builds of SPI_ARB_TIMEOUT_EN.
module tb_spi_master_arbiter;

  localparam int MS  = 4;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int GP  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_cpol = '0;
  logic [3:0]  req_cpha = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  rsp_data;
  logic [3:0]  cs_n;
  logic        m_start;
  logic [7:0]  m_data_in;
  logic        m_cpol;
  logic        m_cpha;
  logic        m_busy = 1'b0;
  logic [7:0]  m_data_out = '0;
  logic        err_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef SPI_ARB_TIMEOUT_EN
  spi_master_arbiter #(.N(4), .TIMEOUT(16)) dut (
`else
  spi_master_arbiter #(.N(4)) dut (
`endif
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .req_cpol   (req_cpol),
    .req_cpha   (req_cpha),
    .gnt        (gnt),
    .done       (done),
    .rsp_data   (rsp_data),
    .cs_n       (cs_n),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_cpol     (m_cpol),
    .m_cpha     (m_cpha),
    .m_busy     (m_busy),
    .m_data_out (m_data_out)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .err        (err_w)
`endif
  );
`ifndef SPI_ARB_TIMEOUT_EN
  assign err_w = 1'b0;
`endif

  // spi_master model: busy for 7 cycles after a start, then returns a byte.
  logic       stuck = 1'b0;
  logic       echo_inv = 1'b0;
  logic [7:0] echo_val = '0;
  logic [7:0] sent = '0;
  int         bcnt = 0;

  always @(posedge clk) begin
    if (m_start && !stuck) begin
      m_busy <= 1'b1;
      bcnt   <= 6;
      sent   <= m_data_in;
    end else if (m_busy) begin
      if (bcnt == 0) begin
        m_busy     <= 1'b0;
        m_data_out <= echo_inv ? ~sent : echo_val;
      end else begin
        bcnt <= bcnt - 1;
      end
    end
  end

  // Bus monitor: CS exclusivity, mode stability, mode-to-CS setup, inter-transaction gap.
  int         n_start = 0;
  int         v_onecs = 0;
  int         v_mode  = 0;
  int         v_age   = 0;
  int         v_gap   = 0;
  int         cfg_age = 100;
  int         hi_cnt  = 100;
  logic [3:0] cs_prev = 4'hF;
  logic       pc = 1'b0;
  logic       ph = 1'b0;

  always @(negedge clk) begin
    if (m_start) n_start <= n_start + 1;
    if ($countones(~cs_n) > 1) v_onecs <= v_onecs + 1;
    if (m_cpol !== pc || m_cpha !== ph) begin
      cfg_age <= 1;
      if (cs_n != 4'hF) v_mode <= v_mode + 1;
    end else begin
      cfg_age <= cfg_age + 1;
    end
    pc <= m_cpol;
    ph <= m_cpha;
    if (cs_n == 4'hF) hi_cnt <= hi_cnt + 1;
    else hi_cnt <= 0;
    if (cs_prev == 4'hF && cs_n != 4'hF) begin
      if (cfg_age < MS) v_age <= v_age + 1;
      if (hi_cnt < GP) v_gap <= v_gap + 1;
    end
    cs_prev <= cs_n;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bounded wait for a done pulse (checked at the current sample first), then confirm it is one cycle wide.
  task automatic wait_done(output int idx, output logic [7:0] rd, output logic e);
    logic found;
    found = 1'b0;
    idx   = -1;
    rd    = '0;
    e     = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done != 4'b0000) begin
        found = 1'b1;
        rd    = rsp_data;
        e     = err_w;
        for (int k = 0; k < 4; k++) if (done[k]) idx = k;
        break;
      end
      @(negedge clk);
    end
    check_val("done_seen", 32'(found), 32'd1);
    $display("txn requester=%0d rsp=%02h err=%0b", idx, rd, e);
    @(negedge clk);
    check_val("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int         idx;
    int         cyc;
    int         h;
    int         bad;
    int         s0;
    int         nd;
    logic [7:0] rd;
    logic [7:0] ev;
    logic       e;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_rsp", 32'(rsp_data), 32'd0);
    check_val("rst_cs_n", 32'(cs_n), 32'hF);
    check_val("rst_m_start", 32'(m_start), 32'd0);
    check_val("rst_m_data_in", 32'(m_data_in), 32'd0);
    check_val("rst_m_cpol", 32'(m_cpol), 32'd0);
    check_val("rst_m_cpha", 32'(m_cpha), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single requester 0, mode 0, engine replies 3C. m_start appears in the
    // 8th cycle counting the one in which req rose (1+MS+CSS+1).
    req_data[7:0] = 8'hA5;
    echo_val      = 8'h3C;
    s0            = n_start;
    req           = 4'b0001;
    cyc           = 1;
    while (m_start !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val("lat_req_to_start", 32'(cyc), 32'(1 + MS + CSS + 1));
    check_val("cs_at_start", 32'(cs_n), 32'hE);
    check_val("m_data_in", 32'(m_data_in), 32'hA5);
    h = 0;
    while (!m_busy && h < 50) begin
      @(negedge clk);
      h++;
    end
    bad = 0;
    h   = 0;
    while (m_busy && h < 100) begin
      if (cs_n != 4'b1110) bad++;
      @(negedge clk);
      h++;
    end
    check_val("cs0_low_during_busy", 32'(bad), 32'd0);
    // One edge for the arbiter to observe m_busy low, then CS_HOLD edges to release.
    @(negedge clk);
    h = 0;
    while (cs_n != 4'hF && h < 50) begin
      @(negedge clk);
      h++;
    end
    check_val("hold_busy_to_cs", 32'(h), 32'(CSH));
    wait_done(idx, rd, e);
    req = 4'b0000;
    check_val("t1_idx", 32'(idx), 32'd0);
    check_val("t1_rsp", 32'(rd), 32'h3C);
    check_val("t1_one_start", 32'(n_start - s0), 32'd1);
    repeat (6) @(negedge clk);

    // All four requesting, modes 0..3, engine returns inverted byte; order 0,1,2,3,0.
    do_reset(2);
    req_data = 32'h13121110;
    req_cpol = 4'b1100;
    req_cpha = 4'b1010;
    echo_inv = 1'b1;
    req      = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_done(idx, rd, e);
      ev = ~(8'h10 + 8'(t % 4));
      check_val("rr_order", 32'(idx), 32'(t % 4));
      check_val("rr_rsp", 32'(rd), 32'(ev));
      check_val("rr_mode", 32'({m_cpol, m_cpha}), 32'(t % 4));
      if (t == 4) req = 4'b0000;
    end
    repeat (6) @(negedge clk);

    // Requester 2 wins from a fresh pointer and drops req one cycle after grant; 3 goes next.
    do_reset(2);
    req = 4'b1100;
    h   = 0;
    while (gnt == 4'b0000 && h < 50) begin
      @(negedge clk);
      h++;
    end
    check_val("drop_gnt2", 32'(gnt), 32'h4);
    @(negedge clk);
    req = 4'b1000;
    wait_done(idx, rd, e);
    check_val("drop_idx", 32'(idx), 32'd2);
    check_val("drop_rsp", 32'(rd), 32'hED);
    wait_done(idx, rd, e);
    check_val("after_drop_idx", 32'(idx), 32'd3);
    req = 4'b0000;
    repeat (6) @(negedge clk);

    // Reset while the engine is busy: CS and grant clear on the next edge.
    req = 4'b0001;
    h   = 0;
    while (!m_busy && h < 100) begin
      @(negedge clk);
      h++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_val("midrst_cs_n", 32'(cs_n), 32'hF);
    check_val("midrst_gnt", 32'(gnt), 32'd0);
    req = 4'b0000;
    h   = 0;
    while (m_busy && h < 100) begin
      @(negedge clk);
      h++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    req     = 4'b0010;
    wait_done(idx, rd, e);
    check_val("postrst_idx", 32'(idx), 32'd1);
    check_val("postrst_rsp", 32'(rd), 32'hEE);
    req = 4'b0000;
    repeat (6) @(negedge clk);

    // Engine never goes busy.
    stuck = 1'b1;
    req   = 4'b0001;
`ifdef SPI_ARB_TIMEOUT_EN
    wait_done(idx, rd, e);
    check_val("to_idx", 32'(idx), 32'd0);
    check_val("to_rsp", 32'(rd), 32'hFF);
    check_val("to_err", 32'(e), 32'd1);
    req = 4'b0000;
`else
    nd = 0;
    repeat (300) begin
      @(negedge clk);
      if (done != 4'b0000) nd++;
    end
    check_val("stuck_no_done", 32'(nd), 32'd0);
    check_val("stuck_cs_held", 32'(cs_n), 32'hE);
    req = 4'b0000;
`endif
    stuck = 1'b0;
    do_reset(2);
    check_val("final_cs_n", 32'(cs_n), 32'hF);

    // Bus-level properties accumulated over the whole run.
    check_val("one_cs_low", 32'(v_onecs), 32'd0);
    check_val("mode_stable_cs_low", 32'(v_mode), 32'd0);
    check_val("mode_setup_before_cs", 32'(v_age), 32'd0);
    check_val("cs_gap", 32'(v_gap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master engine between N requesters; each requester has its own chip-select line and SPI mode (CPOL/CPHA).
- Round-robin arbitration, one 8-bit transfer per grant.
- Sequences mode setup, CS assertion, start pulse, completion wait and CS release, then returns received byte to the winner.
- Sits between peripheral drivers (ADC/DAC/flash pollers) and the single spi_master instance.

Parameters:
- N, 4, number of requesters (2..8).
- MODE_SETUP, 4, clk cycles config is held with all CS high before CS falls (lets SCLK settle to new CPOL).
- CS_SETUP, 2, clk cycles CS low before m_start.
- CS_HOLD, 2, clk cycles CS stays low after m_busy falls.
- GAP, 2, clk cycles all CS high between transactions.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- req  in  N  request per requester; level, held until done
- req_data  in  8*N  byte to send; requester k uses bits [8k+7:8k]
- req_cpol  in  N  CPOL per requester
- req_cpha  in  N  CPHA per requester
- gnt  out  N  one-hot, high from SETUP through HOLD for the winner
- done  out  N  one-cycle pulse to winner when rsp_data valid
- rsp_data  out  8  byte received, valid while done is high
- cs_n  out  N  per-slave chip select, active-low
- m_start  out  1  one-cycle start pulse to spi_master
- m_data_in  out  8  byte to spi_master
- m_cpol  out  1  CPOL to spi_master
- m_cpha  out  1  CPHA to spi_master
- m_busy  in  1  spi_master busy
- m_data_out  in  8  byte received by spi_master

Behaviour:
- Reset (reset_n=0 at posedge clk): state=IDLE, gnt=0, done=0, rsp_data=0, cs_n=all 1, m_start=0, m_data_in=0, m_cpol=0, m_cpha=0, rr pointer=N-1. Reset mid-transfer: CS released in the same edge; spi_master is not otherwise aborted.
- All outputs registered.
- States: IDLE, MSETUP, CSSETUP, START, WAITB, XFER, HOLD, RESP, GAP.
- IDLE: if any req, winner = first set bit searching from ptr+1 upward, modulo N. Latch winner index, req_data slice, cpol, cpha into m_* registers. Set gnt. Go to MSETUP.
- MSETUP: counter MODE_SETUP cycles, cs_n all high, then cs_n[winner]=0 and go to CSSETUP.
- CSSETUP: CS_SETUP cycles, then START.
- START: m_start=1 for exactly one cycle, go to WAITB.
- WAITB: wait for m_busy=1, then XFER. If m_busy is already high on entry, move on immediately.
- XFER: wait for m_busy=0, capture m_data_out into rsp_data, go to HOLD.
- HOLD: CS_HOLD cycles, then cs_n all high, gnt=0, go to RESP.
- RESP: done[winner]=1 for one cycle, ptr=winner, go to GAP.
- GAP: GAP cycles, then IDLE.
- Latency, req rising with idle arbiter to m_start: 1+MODE_SETUP+CS_SETUP+1 cycles.
- Requests dropped after grant are ignored; the transfer completes and done still pulses. req_data, cpol and cpha changes after latch are ignored.
- Single requester repeating: served every transaction, GAP enforced.
- Counters sized $clog2(max param)+1; a parameter value of 0 means a single-cycle pass-through of that state.
- Never more than one cs_n low; cs_n never low while m_cpol differs from SCLK idle, which MSETUP guarantees.

Optional Feature:
- SPI_ARB_TIMEOUT_EN:
  - Defined: WAITB+XFER watchdog, parameter TIMEOUT default 4096 clk. On expiry, go to HOLD with rsp_data=8'hFF and assert extra output port err (1 bit, pulses with done).
  - Undefined: no watchdog, no err port; the arbiter waits on m_busy indefinitely.

Decomposition:
- Package spi_arb_pkg: state encoding localparams (IDLE=0..GAP=8), default timing constants, TIMEOUT default.
- One sub-module rr_arbiter (N-bit req, ptr in, one-hot grant + index out, combinational) instantiated once. The FSM/counter logic stays in the top.

Test Plan:
- req=4'b0001, data 8'hA5, mode 0; spi_master model echoes 8'h3C → cs_n[0] low for the whole transfer, one m_start, done[0] pulses, rsp_data=8'h3C.
- req=4'b1111 held, modes 0..3 → grant order 0,1,2,3,0. m_cpol/m_cpha change only while cs_n=4'hF, at least MODE_SETUP cycles before CS falls.
- req[2] dropped one cycle after gnt → transfer completes, done[2] pulses, next winner is 3.
- reset_n low during XFER → cs_n=4'hF and gnt=0 next edge. After release, req[1] is served normally.
- m_busy stuck 0 with SPI_ARB_TIMEOUT_EN, TIMEOUT=16 → after 16 cycles err=1, done pulses, rsp_data=8'hFF. Without the macro the arbiter stays in WAITB.
- Timing check with defaults: req rise to m_start = 8 cycles. m_busy fall to cs_n rise = 2 cycles. Consecutive transactions have at least 2 cycles of all-high cs_n.
